// File: rtl/mac_address_cam_table.sv
// mac_address_cam_table
// Learning MAC address table for a small switch. Lookups compare a 48-bit
// key against every valid entry in parallel and return a registered
// hit/miss pulse one cycle later. Learn requests update an existing entry,
// fill the lowest free slot, or replace round-robin when the table is full.
// A free-running aging counter periodically ages entries and expires stale ones.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-high reset
//   match_valid      one-cycle lookup request, key on write_data
//   write_data       48-bit MAC key for lookups and learns
//   write_data_valid one-cycle learn request (write_data -> index)
//   index            port to learn for write_data
//   match_index      port of the hit entry, held on a miss
//   match_enable     one-cycle hit pulse
//   no_match         one-cycle miss pulse
//   entry_count      number of valid entries
module mac_address_cam_table #(
  parameter int          NUMBER_OF_PORTS = 2,
  parameter int          TABLE_DEPTH     = 32,
  parameter logic [31:0] AGE_TICK_CYCLES = 32'd1000,
  parameter logic [3:0]  AGE_MAX         = 4'd15
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               match_valid,
  input  logic [47:0]                        write_data,
  input  logic                               write_data_valid,
  input  logic [$clog2(NUMBER_OF_PORTS)-1:0] index,
  output logic [$clog2(NUMBER_OF_PORTS)-1:0] match_index,
  output logic                               match_enable,
  output logic                               no_match,
  output logic [$clog2(TABLE_DEPTH):0]       entry_count
);

  localparam int PW = $clog2(NUMBER_OF_PORTS);
  localparam int IW = $clog2(TABLE_DEPTH);
  localparam int CW = IW + 1;

  logic [TABLE_DEPTH-1:0] valid_q;
  logic [TABLE_DEPTH-1:0] valid_d;
  logic [47:0]            mac_q  [TABLE_DEPTH];
  logic [PW-1:0]          port_q [TABLE_DEPTH];
  logic [3:0]             age_q  [TABLE_DEPTH];
  logic [IW-1:0]          victim_q;
  logic [31:0]            age_cnt_q;

  logic [TABLE_DEPTH-1:0] hit_vec;
  logic                   hit_any;
  logic [IW-1:0]          hit_idx;
  logic [PW-1:0]          hit_port;
  logic                   free_any;
  logic [IW-1:0]          free_idx;
  logic                   key_group;
  logic                   tick;
  logic                   wr_en;
  logic                   wr_replace;
  logic [IW-1:0]          wr_idx;
  logic [CW-1:0]          count_d;
  logic                   lookup_hit;

  // Broadcast has bit 40 set as well; both forms are spelled out for clarity.
  assign key_group  = (write_data == 48'hFFFF_FFFF_FFFF) || write_data[40];
  assign tick       = (age_cnt_q == AGE_TICK_CYCLES - 32'd1);
  assign wr_en      = write_data_valid && !key_group;
  assign wr_replace = wr_en && !hit_any && !free_any;
  assign wr_idx     = hit_any ? hit_idx : (free_any ? free_idx : victim_q);
  assign lookup_hit = match_valid && !key_group && hit_any;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < TABLE_DEPTH; i++)
      hit_vec[i] = valid_q[i] && (mac_q[i] == write_data);
  end

  // Descending scan so the lowest-numbered hit / free slot wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    hit_port = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any  = 1'b1;
        hit_idx  = IW'(i);
        hit_port = port_q[i];
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Expiry first, then the write, so a write coinciding with a tick wins.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < TABLE_DEPTH; i++)
      if (tick && valid_q[i] && (age_q[i] == AGE_MAX))
        valid_d[i] = 1'b0;
    if (wr_en)
      valid_d[wr_idx] = 1'b1;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < TABLE_DEPTH; i++)
      count_d = count_d + CW'(valid_d[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      victim_q     <= '0;
      age_cnt_q    <= '0;
      entry_count  <= '0;
      match_index  <= '0;
      match_enable <= 1'b0;
      no_match     <= 1'b0;
      for (int i = 0; i < TABLE_DEPTH; i++)
        age_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      entry_count <= count_d;
      age_cnt_q   <= tick ? 32'd0 : age_cnt_q + 32'd1;
      if (wr_replace)
        victim_q <= (victim_q == IW'(TABLE_DEPTH - 1)) ? '0 : victim_q + 1'b1;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        if (wr_en && (wr_idx == IW'(i)))
          age_q[i] <= '0;
        else if (tick && valid_q[i] && (age_q[i] != AGE_MAX))
          age_q[i] <= age_q[i] + 4'd1;
      end
      match_enable <= lookup_hit;
      no_match     <= match_valid && !lookup_hit;
      if (lookup_hit)
        match_index <= hit_port;
    end
  end

  // Key and port storage needs no reset: valid_q gates every use.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mac_q[wr_idx]  <= write_data;
      port_q[wr_idx] <= index;
    end
  end

endmodule

// File: tb/tb_mac_address_cam_table.sv
module tb_mac_address_cam_table;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        match_valid = 1'b0;
  logic [47:0] write_data = '0;
  logic        write_data_valid = 1'b0;
  logic [0:0]  index = '0;

  logic [0:0]  match_index;
  logic        match_enable;
  logic        no_match;
  logic [5:0]  entry_count;

  logic [0:0]  age_match_index;
  logic        age_match_enable;
  logic        age_no_match;
  logic [5:0]  age_entry_count;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] MAC_A = 48'h00_11_22_33_44_55;
  localparam logic [47:0] MAC_U = 48'h00_11_22_33_44_66;
  localparam logic [47:0] MAC_B = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MAC_M = 48'h01_00_5E_00_00_01;
  localparam logic [47:0] MAC_N = 48'h00_AA_BB_CC_DD_EE;
  localparam logic [47:0] MAC_K = 48'h0A_0B_0C_0D_0E_0F;

  mac_address_cam_table dut (
    .clock            (clock),
    .reset            (reset),
    .match_valid      (match_valid),
    .write_data       (write_data),
    .write_data_valid (write_data_valid),
    .index            (index),
    .match_index      (match_index),
    .match_enable     (match_enable),
    .no_match         (no_match),
    .entry_count      (entry_count)
  );

  mac_address_cam_table #(
    .AGE_TICK_CYCLES (32'd4),
    .AGE_MAX         (4'd2)
  ) dut_age (
    .clock            (clock),
    .reset            (reset),
    .match_valid      (match_valid),
    .write_data       (write_data),
    .write_data_valid (write_data_valid),
    .index            (index),
    .match_index      (age_match_index),
    .match_enable     (age_match_enable),
    .no_match         (age_no_match),
    .entry_count      (age_entry_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic learn(input logic [47:0] mac, input logic p);
    write_data       = mac;
    index            = p;
    write_data_valid = 1'b1;
    step();
    write_data_valid = 1'b0;
  endtask

  task automatic lookup(input logic [47:0] mac);
    write_data  = mac;
    match_valid = 1'b1;
    step();
    match_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  function automatic logic [47:0] fill_mac(input int i);
    return 48'h02_00_00_00_00_00 + 48'(i);
  endfunction

  initial begin
    logic p;

    // reset state
    step();
    step();
    check("rst_match_enable", 64'(match_enable), 64'd0);
    check("rst_no_match", 64'(no_match), 64'd0);
    check("rst_match_index", 64'(match_index), 64'd0);
    check("rst_entry_count", 64'(entry_count), 64'd0);
    reset = 1'b0;
    step();

    // learn then immediate lookup
    learn(MAC_A, 1'b1);
    lookup(MAC_A);
    check("learn_hit_enable", 64'(match_enable), 64'd1);
    check("learn_hit_nomatch", 64'(no_match), 64'd0);
    check("learn_hit_index", 64'(match_index), 64'd1);
    check("learn_count", 64'(entry_count), 64'd1);
    step();
    check("hit_pulse_one_cycle", 64'(match_enable), 64'd0);

    // misses: unknown, broadcast, multicast
    lookup(MAC_U);
    check("unknown_no_match", 64'(no_match), 64'd1);
    check("unknown_enable", 64'(match_enable), 64'd0);
    check("miss_index_held", 64'(match_index), 64'd1);
    lookup(MAC_B);
    check("bcast_no_match", 64'(no_match), 64'd1);
    lookup(MAC_M);
    check("mcast_no_match", 64'(no_match), 64'd1);
    learn(MAC_B, 1'b0);
    learn(MAC_M, 1'b0);
    check("group_write_ignored", 64'(entry_count), 64'd1);
    lookup(MAC_A);
    check("table_unchanged", 64'(match_enable), 64'd1);

    // relearn same MAC on another port
    do_reset();
    learn(MAC_A, 1'b0);
    lookup(MAC_A);
    check("relearn_p0_index", 64'(match_index), 64'd0);
    learn(MAC_A, 1'b1);
    lookup(MAC_A);
    check("relearn_p1_index", 64'(match_index), 64'd1);
    check("relearn_count", 64'(entry_count), 64'd1);

    // fill and round-robin replacement
    do_reset();
    for (int i = 0; i < 32; i++) begin
      p = 1'(i % 2);
      learn(fill_mac(i), p);
    end
    check("full_count", 64'(entry_count), 64'd32);
    learn(fill_mac(32), 1'b1);
    check("replace_count", 64'(entry_count), 64'd32);
    lookup(fill_mac(0));
    check("slot0_evicted", 64'(no_match), 64'd1);
    lookup(fill_mac(32));
    check("mac32_hit", 64'(match_enable), 64'd1);
    check("mac32_index", 64'(match_index), 64'd1);
    learn(fill_mac(33), 1'b1);
    lookup(fill_mac(1));
    check("slot1_evicted", 64'(no_match), 64'd1);
    lookup(fill_mac(2));
    check("mac2_hit", 64'(match_enable), 64'd1);
    check("mac2_index", 64'(match_index), 64'd0);
    lookup(fill_mac(33));
    check("mac33_hit", 64'(match_enable), 64'd1);
    check("mac33_index", 64'(match_index), 64'd1);
    check("full_count_after", 64'(entry_count), 64'd32);

    // simultaneous lookup and learn of a new MAC
    do_reset();
    write_data       = MAC_N;
    index            = 1'b1;
    match_valid      = 1'b1;
    write_data_valid = 1'b1;
    step();
    match_valid      = 1'b0;
    write_data_valid = 1'b0;
    check("simul_no_match", 64'(no_match), 64'd1);
    check("simul_enable", 64'(match_enable), 64'd0);
    lookup(MAC_N);
    check("after_simul_hit", 64'(match_enable), 64'd1);
    check("after_simul_index", 64'(match_index), 64'd1);

    // aging: tick every 4 cycles, expire after age 2
    do_reset();
    learn(MAC_K, 1'b1);
    repeat (8) step();
    check("age_alive_8", 64'(age_entry_count), 64'd1);
    repeat (4) step();
    check("age_expired_count", 64'(age_entry_count), 64'd0);
    lookup(MAC_K);
    check("age_expired_lookup", 64'(age_no_match), 64'd1);
    learn(MAC_K, 1'b1);
    for (int r = 0; r < 4; r++) begin
      repeat (7) step();
      learn(MAC_K, 1'b1);
    end
    check("age_kept_count", 64'(age_entry_count), 64'd1);
    lookup(MAC_K);
    check("age_kept_hit", 64'(age_match_enable), 64'd1);

    // reset during a pending lookup
    learn(MAC_A, 1'b1);
    check("pre_reset_count", 64'(entry_count), 64'd2);
    write_data  = MAC_A;
    match_valid = 1'b1;
    #2;
    reset = 1'b1;
    step();
    check("in_reset_enable", 64'(match_enable), 64'd0);
    check("in_reset_no_match", 64'(no_match), 64'd0);
    match_valid = 1'b0;
    reset = 1'b0;
    step();
    check("post_reset_enable", 64'(match_enable), 64'd0);
    check("post_reset_no_match", 64'(no_match), 64'd0);
    check("post_reset_count", 64'(entry_count), 64'd0);
    check("post_reset_index", 64'(match_index), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
